// File: rtl/alu_regfile_if.sv
// alu_regfile_if
//   Bundles the execute-stage datapath signals of alu_regfile.
//   Register file: addrA/addrB (read addresses), addrW/dataIn/WE (write port),
//                  A/B (read data).
//   ALU:           a/b (operands), op (function), shift (left shift of b),
//                  out (result), zero/negative (result flags).
//   master: the processor side driving addresses, operands and controls.
//   slave:  the datapath core (alu_regfile) producing read data and results.
interface alu_regfile_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    addrA;
  logic [AW-1:0]    addrB;
  logic [AW-1:0]    addrW;
  logic [WIDTH-1:0] dataIn;
  logic             WE;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [3:0]       shift;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             negative;

  modport master (
    output addrA, addrB, addrW, dataIn, WE, a, b, op, shift,
    input  A, B, out, zero, negative
  );

  modport slave (
    input  addrA, addrB, addrW, dataIn, WE, a, b, op, shift,
    output A, B, out, zero, negative
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile
//   Execute-stage datapath core: a NREGS x WIDTH register file with two
//   combinational read ports and one synchronous write port, plus a
//   combinational 4-function ALU whose operand b is left-shifted by 0-15.
//   Ports:
//     clk    - single clock, all state changes on the rising edge
//     reset  - synchronous, active-high; clears every register, beats WE
//     bus    - alu_regfile_if.slave carrying register-file and ALU signals
module alu_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input logic          clk,
  input logic          reset,
  alu_regfile_if.slave bus
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic [WIDTH-1:0] regs [NREGS];

  // No hardwired zero register and no write-to-read bypass: reads see the
  // old value until the write edge has passed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WE) begin
      regs[bus.addrW] <= bus.dataIn;
    end
  end

  assign bus.A = regs[bus.addrA];
  assign bus.B = regs[bus.addrB];

  logic [WIDTH-1:0] bs;
  logic [WIDTH-1:0] result;

  assign bs = bus.b << bus.shift;

  always_comb begin
    result = '0;
    unique case (alu_op_e'(bus.op))
      OP_ADD: result = bus.a + bs;
      OP_SUB: result = bus.a - bs;
      OP_AND: result = bus.a & bs;
      OP_OR:  result = bus.a | bs;
    endcase
  end

  assign bus.out      = result;
  assign bus.zero     = (result == '0);
  assign bus.negative = result[WIDTH-1];
endmodule

// File: tb/tb_alu_regfile.sv
module tb_alu_regfile;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_regfile_if #(.WIDTH(32), .NREGS(16)) bus ();

  alu_regfile #(.WIDTH(32), .NREGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: the shift is modelled as multiplication by 2^shift.
  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] sh);
    logic [31:0] mult;
    logic [31:0] bs;
    mult = 32'd1;
    for (int k = 0; k < 16; k++) if (k < int'(sh)) mult = mult * 32'd2;
    bs = b * mult;
    case (op)
      2'b00:   return a + bs;
      2'b01:   return a - bs;
      2'b10:   return a & bs;
      default: return a | bs;
    endcase
  endfunction

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.addrW = addr; bus.dataIn = data; bus.WE = 1'b1;
    @(posedge clk); #1;
    bus.WE = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) write_reg(4'(i), 32'h1000 + 32'(i));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.addrA = 4'(i); bus.addrB = 4'(15 - i); #1;
      n_cmp++;
      if (bus.A !== 32'h0) begin
        n_err++; $display("FAIL reset_A[%0d]: got %h expected %h", i, bus.A, 32'h0);
      end
      n_cmp++;
      if (bus.B !== 32'h0) begin
        n_err++; $display("FAIL reset_B[%0d]: got %h expected %h", 15 - i, bus.B, 32'h0);
      end
    end
  endtask

  task automatic test_write_hold;
    write_reg(4'd5, 32'hDEADBEEF);
    bus.addrA = 4'd5; bus.addrB = 4'd5; #1;
    n_cmp++;
    if (bus.A !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_A: got %h expected %h", bus.A, 32'hDEADBEEF);
    end
    n_cmp++;
    if (bus.B !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_B: got %h expected %h", bus.B, 32'hDEADBEEF);
    end
    @(negedge clk);
    bus.addrW = 4'd5; bus.dataIn = 32'h12345678; bus.WE = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.A !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL hold_A: got %h expected %h", bus.A, 32'hDEADBEEF);
    end
    // Neighbouring register must be untouched by the r5 write.
    bus.addrB = 4'd4; #1;
    n_cmp++;
    if (bus.B !== 32'h0) begin
      n_err++; $display("FAIL neighbour_r4: got %h expected %h", bus.B, 32'h0);
    end
  endtask

  task automatic test_read_during_write;
    write_reg(4'd3, 32'd7);
    @(negedge clk);
    bus.addrA = 4'd3; bus.addrW = 4'd3; bus.dataIn = 32'd9; bus.WE = 1'b1; #1;
    n_cmp++;
    if (bus.A !== 32'd7) begin
      n_err++; $display("FAIL rdw_before: got %h expected %h", bus.A, 32'd7);
    end
    @(posedge clk); #1;
    bus.WE = 1'b0;
    n_cmp++;
    if (bus.A !== 32'd9) begin
      n_err++; $display("FAIL rdw_after: got %h expected %h", bus.A, 32'd9);
    end
    write_reg(4'd0, 32'hCAFE0000);
    bus.addrB = 4'd0; #1;
    n_cmp++;
    if (bus.B !== 32'hCAFE0000) begin
      n_err++; $display("FAIL r0_writable: got %h expected %h", bus.B, 32'hCAFE0000);
    end
    @(negedge clk);
    reset = 1'b1; bus.WE = 1'b1; bus.addrW = 4'd3; bus.dataIn = 32'd55;
    @(posedge clk); #1;
    reset = 1'b0; bus.WE = 1'b0;
    n_cmp++;
    if (bus.A !== 32'h0) begin
      n_err++; $display("FAIL reset_over_we: got %h expected %h", bus.A, 32'h0);
    end
  endtask

  task automatic test_alu_arith;
    bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'd1; bus.shift = 4'd0; #1;
    n_cmp++;
    if ({bus.out, bus.zero, bus.negative} !== {32'h0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_wrap: got %h z%b n%b expected %h z1 n0",
                        bus.out, bus.zero, bus.negative, 32'h0);
    end
    bus.op = 2'b01; bus.a = 32'h0; bus.b = 32'd1; #1;
    n_cmp++;
    if ({bus.out, bus.zero, bus.negative} !== {32'hFFFFFFFF, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL sub_borrow: got %h z%b n%b expected %h z0 n1",
                        bus.out, bus.zero, bus.negative, 32'hFFFFFFFF);
    end
    bus.op = 2'b01; bus.a = 32'd100; bus.b = 32'd1; bus.shift = 4'd2; #1;
    n_cmp++;
    if ({bus.out, bus.zero, bus.negative} !== {32'd96, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sub_shift: got %h z%b n%b expected %h z0 n0",
                        bus.out, bus.zero, bus.negative, 32'd96);
    end
  endtask

  task automatic test_shift;
    bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h3; bus.shift = 4'd4; #1;
    n_cmp++;
    if (bus.out !== 32'h30) begin
      n_err++; $display("FAIL shift4: got %h expected %h", bus.out, 32'h30);
    end
    bus.op = 2'b11; bus.a = 32'h0; bus.b = 32'h80000001; bus.shift = 4'd1; #1;
    n_cmp++;
    if (bus.out !== 32'h2) begin
      n_err++; $display("FAIL shift_trunc: got %h expected %h", bus.out, 32'h2);
    end
    bus.op = 2'b11; bus.a = 32'h0; bus.b = 32'hFFFF; bus.shift = 4'd15; #1;
    n_cmp++;
    if (bus.out !== 32'h7FFF8000) begin
      n_err++; $display("FAIL shift15: got %h expected %h", bus.out, 32'h7FFF8000);
    end
  endtask

  task automatic test_logic;
    bus.shift = 4'd0; bus.a = 32'hF0F0F0F0; bus.b = 32'hFF00FF00;
    bus.op = 2'b10; #1;
    n_cmp++;
    if ({bus.out, bus.negative} !== {32'hF000F000, 1'b1}) begin
      n_err++; $display("FAIL and: got %h n%b expected %h n1", bus.out, bus.negative, 32'hF000F000);
    end
    bus.op = 2'b11; #1;
    n_cmp++;
    if (bus.out !== 32'hFFF0FFF0) begin
      n_err++; $display("FAIL or: got %h expected %h", bus.out, 32'hFFF0FFF0);
    end
    bus.op = 2'b10; bus.a = 32'h0F0F0F0F; bus.b = 32'hF0F0F0F0; #1;
    n_cmp++;
    if ({bus.out, bus.zero} !== {32'h0, 1'b1}) begin
      n_err++; $display("FAIL and_zero: got %h z%b expected %h z1", bus.out, bus.zero, 32'h0);
    end
  endtask

  task automatic test_sweep;
    logic [31:0] model [16];
    logic [31:0] exp_out;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      write_reg(4'(i), model[i]);
    end
    for (int i = 0; i < 16; i++) begin
      bus.addrA = 4'(i); bus.addrB = 4'(15 - i); #1;
      n_cmp++;
      if (bus.A !== model[i]) begin
        n_err++; $display("FAIL sweep_A[%0d]: got %h expected %h", i, bus.A, model[i]);
      end
      n_cmp++;
      if (bus.B !== model[15 - i]) begin
        n_err++; $display("FAIL sweep_B[%0d]: got %h expected %h", 15 - i, bus.B, model[15 - i]);
      end
      for (int o = 0; o < 4; o++) begin
        bus.op = 2'(o); bus.a = model[i]; bus.b = model[15 - i];
        bus.shift = 4'($urandom_range(0, 15)); #1;
        exp_out = alu_ref(2'(o), model[i], model[15 - i], bus.shift);
        n_cmp++;
        if ({bus.out, bus.zero, bus.negative} !== {exp_out, exp_out == 32'h0, exp_out[31]}) begin
          n_err++; $display("FAIL sweep_alu r%0d op%0d: got %h z%b n%b expected %h",
                            i, o, bus.out, bus.zero, bus.negative, exp_out);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.addrA = '0; bus.addrB = '0; bus.addrW = '0; bus.dataIn = '0; bus.WE = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0; bus.shift = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset;
    test_write_hold;
    test_read_during_write;
    test_alu_arith;
    test_shift;
    test_logic;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
